// File: rtl/uart_pkg.sv
// Shared UART encodings: baud selects, divisor helper, parity codes and rx FSM states.
// Used by both the transmitter and the receiver so they can share one settings bus.
`timescale 1ns/1ps
package uart_pkg;

    localparam int BAUD_2400_HZ  = 2400;
    localparam int BAUD_4800_HZ  = 4800;
    localparam int BAUD_9600_HZ  = 9600;
    localparam int BAUD_19200_HZ = 19200;

    localparam logic [1:0] BAUD_2400  = 2'b00;
    localparam logic [1:0] BAUD_4800  = 2'b01;
    localparam logic [1:0] BAUD_9600  = 2'b10;
    localparam logic [1:0] BAUD_19200 = 2'b11;

    localparam logic [1:0] PAR_NONE     = 2'b00;
    localparam logic [1:0] PAR_ODD      = 2'b01;
    localparam logic [1:0] PAR_EVEN     = 2'b10;
    localparam logic [1:0] PAR_NONE_ALT = 2'b11;

    localparam int DIV_W = 16;

    typedef logic [2:0] rx_state_t;
    localparam rx_state_t ST_IDLE   = 3'd0;
    localparam rx_state_t ST_START  = 3'd1;
    localparam rx_state_t ST_DATA   = 3'd2;
    localparam rx_state_t ST_PARITY = 3'd3;
    localparam rx_state_t ST_STOP   = 3'd4;
    localparam rx_state_t ST_DONE   = 3'd5;

    // Rounded clocks per oversample tick for the selected baud.
    function automatic logic [DIV_W-1:0] baud_div(input int clk_freq,
                                                  input logic [1:0] baud_rate,
                                                  input int oversample);
        int hz;
        int den;
        case (baud_rate)
            BAUD_2400:  hz = BAUD_2400_HZ;
            BAUD_4800:  hz = BAUD_4800_HZ;
            BAUD_9600:  hz = BAUD_9600_HZ;
            default:    hz = BAUD_19200_HZ;
        endcase
        den = hz * oversample;
        return DIV_W'((clk_freq + den / 2) / den);
    endfunction

endpackage

// File: rtl/uart_rx_tick_gen.sv
// Oversample tick generator: free-running divisor counter with a synchronous restart.
`timescale 1ns/1ps
module uart_rx_tick_gen
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             arst_n,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    // The >= keeps the counter bounded if the divisor shrinks between frames.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt <= '0;
        end else if (restart || cnt >= div - DIV_W'(1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

    assign tick = !restart && (cnt == div - DIV_W'(1));

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver: 7/8 data bits, optional parity, 1/2 stop bits.
// Optional macro RX_MAJORITY_VOTE_EN: 2-of-3 vote around each bit centre.
`timescale 1ns/1ps
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       rx,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    input  logic       stop_bits,
    input  logic       data_length,
    output logic [7:0] data_out,
    output logic       rx_valid,
    output logic       rx_active,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [DIV_W-1:0] DIV0 = baud_div(CLK_FREQ, BAUD_2400, OVERSAMPLE);
    localparam logic [DIV_W-1:0] DIV1 = baud_div(CLK_FREQ, BAUD_4800, OVERSAMPLE);
    localparam logic [DIV_W-1:0] DIV2 = baud_div(CLK_FREQ, BAUD_9600, OVERSAMPLE);
    localparam logic [DIV_W-1:0] DIV3 = baud_div(CLK_FREQ, BAUD_19200, OVERSAMPLE);

    rx_state_t        state;
    logic             rx_meta, rx_sync, rx_prev;
    logic             armed;
    logic [1:0]       cfg_baud, cfg_par;
    logic             cfg_stop, cfg_len;
    logic [DIV_W-1:0] cur_div;
    logic             tick, start_edge, sample_now, bit_val, par_en;
    logic [TW-1:0]    tick_cnt;
    logic [2:0]       bit_cnt, last_bit;
    logic             stop_cnt;
    logic [7:0]       shift_reg;
    logic             par_err_pend, frm_err_pend;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = (state == ST_IDLE) && armed && rx_prev && !rx_sync;
    assign par_en     = (cfg_par != PAR_NONE) && (cfg_par != PAR_NONE_ALT);
    assign last_bit   = cfg_len ? 3'd7 : 3'd6;

    always_comb begin
        cur_div = DIV3;
        case (cfg_baud)
            BAUD_2400:  cur_div = DIV0;
            BAUD_4800:  cur_div = DIV1;
            BAUD_9600:  cur_div = DIV2;
            default:    cur_div = DIV3;
        endcase
    end

    uart_rx_tick_gen u_tick_gen (
        .clk     (clk),
        .arst_n  (arst_n),
        .restart (start_edge),
        .div     (cur_div),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tick_cnt <= '0;
        end else if (start_edge) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= (tick_cnt == TW'(OVERSAMPLE - 1)) ? '0 : tick_cnt + TW'(1);
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    logic vote_a, vote_b;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            vote_a <= 1'b1;
            vote_b <= 1'b1;
        end else if (tick) begin
            if (tick_cnt == TW'(OVERSAMPLE / 2 - 2)) vote_a <= rx_sync;
            if (tick_cnt == TW'(OVERSAMPLE / 2 - 1)) vote_b <= rx_sync;
        end
    end

    assign sample_now = tick && (tick_cnt == TW'(OVERSAMPLE / 2));
    assign bit_val    = (vote_a & vote_b) | (vote_a & rx_sync) | (vote_b & rx_sync);
`else
    assign sample_now = tick && (tick_cnt == TW'(OVERSAMPLE / 2 - 1));
    assign bit_val    = rx_sync;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state        <= ST_IDLE;
            armed        <= 1'b1;
            cfg_baud     <= '0;
            cfg_par      <= '0;
            cfg_stop     <= 1'b0;
            cfg_len      <= 1'b0;
            bit_cnt      <= '0;
            stop_cnt     <= 1'b0;
            shift_reg    <= '0;
            par_err_pend <= 1'b0;
            frm_err_pend <= 1'b0;
            data_out     <= '0;
            rx_valid     <= 1'b0;
            rx_active    <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (!armed && rx_sync) armed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state        <= ST_START;
                        cfg_baud     <= baud_rate;
                        cfg_par      <= parity_type;
                        cfg_stop     <= stop_bits;
                        cfg_len      <= data_length;
                        bit_cnt      <= '0;
                        stop_cnt     <= 1'b0;
                        shift_reg    <= '0;
                        par_err_pend <= 1'b0;
                        frm_err_pend <= 1'b0;
                    end
                end
                ST_START: begin
                    if (sample_now) begin
                        if (bit_val) begin
                            state <= ST_IDLE;
                        end else begin
                            state     <= ST_DATA;
                            rx_active <= 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (sample_now) begin
                        shift_reg[bit_cnt] <= bit_val;
                        bit_cnt            <= bit_cnt + 3'd1;
                        if (bit_cnt == last_bit) state <= par_en ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    // Error when the ones count disagrees with the selected sense.
                    if (sample_now) begin
                        par_err_pend <= (^shift_reg) ^ bit_val ^ (cfg_par == PAR_ODD);
                        state        <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (sample_now) begin
                        if (!bit_val) frm_err_pend <= 1'b1;
                        if (stop_cnt == cfg_stop) state <= ST_DONE;
                        else stop_cnt <= 1'b1;
                    end
                end
                ST_DONE: begin
                    data_out   <= shift_reg;
                    parity_err <= par_err_pend;
                    frame_err  <= frm_err_pend;
                    rx_valid   <= 1'b1;
                    rx_active  <= 1'b0;
                    state      <= ST_IDLE;
                    // Line held low after a bad stop is a break: wait for idle high.
                    if (!rx_sync && frm_err_pend) armed <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
